// File: rtl/stripe_n_if.sv
// rtl/stripe_n_if.sv - word input stream and lane-group output bundle for stripe_n
interface stripe_n_if #(
    parameter int WIDTH     = 32,
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = $clog2(NUM_LANES + 1)
);
    logic [WIDTH-1:0]           data_in;
    logic                       valid_in;
    logic                       ready_in;
    logic [CNT_W-1:0]           active_lanes;
    logic [NUM_LANES*WIDTH-1:0] lane_data;
    logic [NUM_LANES-1:0]       lane_valid;
    logic                       group_valid;
    logic                       group_ready;
    logic                       group_partial;

    modport master (
        output data_in, valid_in, active_lanes, group_ready,
        input  ready_in, lane_data, lane_valid, group_valid, group_partial
    );

    modport slave (
        input  data_in, valid_in, active_lanes, group_ready,
        output ready_in, lane_data, lane_valid, group_valid, group_partial
    );
endinterface

// File: rtl/stripe_n.sv
// rtl/stripe_n.sv - round-robin word striper onto NUM_LANES registered output lanes
module stripe_n #(
    parameter int WIDTH     = 32,
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = $clog2(NUM_LANES + 1)
) (
    input  logic      clk_2f,
    input  logic      reset,
    stripe_n_if.slave bus
);
    typedef enum logic {FILL, PEND} state_t;

    state_t                     state_q;
    logic                       ready_q;
    logic                       prev_acc_q;
    logic                       pend_partial_q;
    logic [CNT_W-1:0]           ptr_q;
    logic [CNT_W-1:0]           act_q;
    logic [NUM_LANES-1:0]       fill_q;
    logic [WIDTH-1:0]           acc_q [NUM_LANES];
    logic [NUM_LANES*WIDTH-1:0] lane_data_q;
    logic [NUM_LANES-1:0]       lane_valid_q;
    logic                       group_valid_q;
    logic                       group_partial_q;

    logic [CNT_W-1:0]     act_new;
    logic [CNT_W-1:0]     act_d;
    logic [CNT_W-1:0]     ptr_d;
    logic [NUM_LANES-1:0] fill_d;
    logic [WIDTH-1:0]     acc_d [NUM_LANES];
    logic                 accept;
    logic                 complete;
    logic                 flush;
    logic                 close;
    logic                 out_free;
    logic                 load;
    logic                 load_partial;

    always_comb begin
        act_new = (bus.active_lanes == '0 || bus.active_lanes > CNT_W'(NUM_LANES))
                  ? CNT_W'(NUM_LANES) : bus.active_lanes;
        // The lane count only takes effect on the first beat of a group
        act_d        = (ptr_q == '0) ? act_new : act_q;
        accept       = bus.valid_in && ready_q;
        complete     = accept && (ptr_q == act_d - CNT_W'(1));
        flush        = (state_q == FILL) && prev_acc_q && !bus.valid_in && (ptr_q != '0);
        close        = complete || flush;
        out_free     = !group_valid_q || bus.group_ready;
        load         = out_free && ((state_q == FILL && close) || state_q == PEND);
        load_partial = (state_q == PEND) ? pend_partial_q : flush;
        ptr_d        = complete ? '0 : ptr_q + CNT_W'(1);
        for (int k = 0; k < NUM_LANES; k++) begin
            acc_d[k]  = (accept && ptr_q == CNT_W'(k)) ? bus.data_in : acc_q[k];
            fill_d[k] = fill_q[k] | (accept && ptr_q == CNT_W'(k));
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state_q         <= FILL;
            ready_q         <= 1'b0;
            prev_acc_q      <= 1'b0;
            pend_partial_q  <= 1'b0;
            ptr_q           <= '0;
            act_q           <= CNT_W'(NUM_LANES);
            fill_q          <= '0;
            for (int k = 0; k < NUM_LANES; k++) acc_q[k] <= '0;
            lane_data_q     <= '0;
            lane_valid_q    <= '0;
            group_valid_q   <= 1'b0;
            group_partial_q <= 1'b0;
        end else begin
            prev_acc_q <= accept;

            if (load) begin
                for (int k = 0; k < NUM_LANES; k++)
                    lane_data_q[k*WIDTH +: WIDTH] <= fill_d[k] ? acc_d[k] : '0;
                lane_valid_q    <= fill_d;
                group_valid_q   <= 1'b1;
                group_partial_q <= load_partial;
            end else if (group_valid_q && bus.group_ready) begin
                lane_data_q     <= '0;
                lane_valid_q    <= '0;
                group_valid_q   <= 1'b0;
                group_partial_q <= 1'b0;
            end

            case (state_q)
                FILL: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        for (int k = 0; k < NUM_LANES; k++) acc_q[k] <= acc_d[k];
                        fill_q <= fill_d;
                        ptr_q  <= ptr_d;
                        if (ptr_q == '0) act_q <= act_new;
                    end
                    // A closed group that cannot reach the output stays parked in the bank
                    if (close) begin
                        ptr_q <= '0;
                        if (out_free) begin
                            fill_q <= '0;
                        end else begin
                            state_q        <= PEND;
                            ready_q        <= 1'b0;
                            pend_partial_q <= flush;
                        end
                    end
                end
                PEND: begin
                    if (out_free) begin
                        state_q <= FILL;
                        ready_q <= 1'b1;
                        fill_q  <= '0;
                        ptr_q   <= '0;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.ready_in      = ready_q;
    assign bus.lane_data     = lane_data_q;
    assign bus.lane_valid    = lane_valid_q;
    assign bus.group_valid   = group_valid_q;
    assign bus.group_partial = group_partial_q;
endmodule
